mem_arb_mc: RTL and testbench
=============================

MEM_ARB_MC -- requirements
Module: mem_arb_mc

Interface
REQ-001 Parameters (name, default, meaning): WIDTH, 8, data width in bits, a multiple of 8 | DEPTH, 32, number of words | NUM_CH, 2, requester channels, 1..8 | ADDR_WIDTH, $clog2(DEPTH), address width | RD_LAT, 1, access wait cycles, 1..4.
REQ-002 Ports (name, direction, width, meaning):
clk  input  1  single clock; all logic is rising-edge.
rst  input  1  asynchronous reset, active-low (asserted at 0).
valid  input  NUM_CH  per-channel request.
wr_rd  input  NUM_CH  per-channel 1=write, 0=read.
addr  input  NUM_CH*ADDR_WIDTH  flattened; channel c occupies slice [c*ADDR_WIDTH +: ADDR_WIDTH].
wdata  input  NUM_CH*WIDTH  flattened write data.
wstrb  input  NUM_CH*WIDTH/8  flattened byte enables.
ready  output  NUM_CH  per-channel one-cycle completion pulse.
rdata  output  NUM_CH*WIDTH  flattened read data, valid while ready[c]=1.
err  output  NUM_CH  out-of-range flag, valid while ready[c]=1.

Function
REQ-003 Handshake: a requester holds valid, wr_rd, addr, wdata and wstrb stable until its ready pulse; a transfer completes in the cycle ready[c]=1.
REQ-004 FSM states IDLE, ACCESS, RESP; one transaction in flight at a time.
REQ-005 IDLE: if any valid=1, grant the round-robin winner, latch its request fields, load wait counter with RD_LAT-1, go to ACCESS; otherwise remain in IDLE.
REQ-006 Round-robin: search starts at pointer ptr; after each RESP, ptr = (grant+1) mod NUM_CH; ptr resets to 0.
REQ-007 ACCESS: decrement the counter each cycle; go to RESP when it reaches 0 (RD_LAT=1 gives 1 cycle in ACCESS).
REQ-008 RESP: ready[grant]=1 for exactly one cycle; for a write, commit the bytes with wstrb=1 to mem[addr]; for a read, drive rdata slice of grant = mem[addr]; return to IDLE.
REQ-009 Latency: valid sampled in IDLE at edge N -> ready high in cycle N+RD_LAT+1; back-to-back throughput is one transfer per RD_LAT+2 cycles.
REQ-010 Out-of-range: addr >= DEPTH -> err=1 and ready=1 in RESP, no array write, rdata=0.
REQ-011 A write with wstrb all zero completes normally and leaves memory unchanged.
REQ-012 Non-granted channels see ready=0, err=0 and rdata=0 in all cycles.
REQ-013 If valid drops after grant, the latched transaction still completes and ready still pulses.
REQ-014 Read-after-write to the same address returns the new data when the read is granted after the write's RESP.

Reset
REQ-015 While rst=0: FSM=IDLE, ptr=0, counter=0, ready=0, err=0, rdata=0, all memory words=0; asserted asynchronously, released synchronously to clk.
REQ-016 Reset during ACCESS aborts the transaction; a pending write is not committed and no ready is issued.

Structure
REQ-017 A shared package mem_pkg holds the FSM state enumeration (IDLE, ACCESS, RESP) and the RD_LAT bound constants.
REQ-018 The round-robin arbiter is the single sub-module, rr_arbiter, parametrised by NUM_CH, with inputs req and ptr and outputs grant_idx and grant_vld.

Verification
REQ-019 Reset with rst=0 for 2 cycles, then release -> all outputs 0; a read of every address returns 0.
REQ-020 Channel 0 writes 0xA5 to addr 3 with wstrb=1, then reads addr 3 -> rdata=0xA5, err=0, and ready arrives RD_LAT+1 cycles after grant (checked for RD_LAT=1 and RD_LAT=3).
REQ-021 Both channels hold valid continuously for 8 transfers -> grants alternate 0,1,0,1,...; each ready is one cycle wide.
REQ-022 With WIDTH=16, write 0x1234 to addr 5, then write 0xFF00 to addr 5 with wstrb=2'b10 -> a read of addr 5 returns 0xFF34.
REQ-023 With DEPTH=20, a write to addr 25 gives err=1 and ready=1; a subsequent read of addr 25 gives rdata=0 and err=1, and addr 5 (25 mod 20) is unchanged.
REQ-024 Assert rst=0 during the ACCESS state of a write of 0x77 to addr 7 -> no ready pulse occurs, and a read of addr 7 after reset returns 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the arbitrated single-port memory controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;
    localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first asserted req at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [PTR_W-1:0]  grant_idx,
    output logic              grant_vld
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = PTR_W'((32'(ptr) + i) % NUM_CH);
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/mem_arb_mc.sv
// Multi-channel memory controller: round-robin arbitration in front of a
// byte-maskable register-file memory, one transaction in flight at a time.
module mem_arb_mc
    import mem_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            valid,
    input  logic [NUM_CH-1:0]            wr_rd,
    input  logic [NUM_CH*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_CH*WIDTH-1:0]      wdata,
    input  logic [NUM_CH*WIDTH/8-1:0]    wstrb,
    output logic [NUM_CH-1:0]            ready,
    output logic [NUM_CH*WIDTH-1:0]      rdata,
    output logic [NUM_CH-1:0]            err
);

    localparam int unsigned STRB_W = WIDTH / 8;
    localparam int unsigned PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, gnt_q, grant_idx;
    logic                  grant_vld;
    logic [CNT_W-1:0]      cnt_q;
    logic                  wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [WIDTH-1:0]      wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [WIDTH-1:0]      mem [DEPTH];

    logic                  oor_c, last_c, mem_we_c;
    logic [NUM_CH-1:0]     ready_d, err_d;
    logic [NUM_CH*WIDTH-1:0] rdata_d;

    rr_arbiter #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_arb (
        .req       (valid),
        .ptr       (ptr_q),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    assign oor_c  = (32'(addr_q) >= DEPTH);
    assign last_c = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_vld) state_d = ACCESS;
            ACCESS:  if (last_c)    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Response values are computed on the last ACCESS cycle so the output
    // registers present them for exactly the RESP cycle.
    always_comb begin
        ready_d  = '0;
        err_d    = '0;
        rdata_d  = '0;
        mem_we_c = 1'b0;
        if (state_q == ACCESS && last_c) begin
            ready_d[gnt_q] = 1'b1;
            err_d[gnt_q]   = oor_c;
            if (!wr_q && !oor_c) rdata_d[32'(gnt_q)*WIDTH +: WIDTH] = mem[addr_q];
        end
        if (state_q == RESP && wr_q && !oor_c) mem_we_c = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ready   <= '0;
            err     <= '0;
            rdata   <= '0;
        end else begin
            if (state_q == IDLE && grant_vld) begin
                gnt_q   <= grant_idx;
                wr_q    <= wr_rd[grant_idx];
                addr_q  <= addr[32'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= wdata[32'(grant_idx)*WIDTH +: WIDTH];
                wstrb_q <= wstrb[32'(grant_idx)*STRB_W +: STRB_W];
                cnt_q   <= CNT_W'(RD_LAT - 1);
            end else if (state_q == ACCESS && !last_c) begin
                cnt_q   <= cnt_q - CNT_W'(1);
            end
            if (state_q == RESP) begin
                ptr_q <= (32'(gnt_q) == NUM_CH - 1) ? '0 : gnt_q + PTR_W'(1);
            end
            ready <= ready_d;
            err   <= err_d;
            rdata <= rdata_d;
        end
    end

    // Byte-masked commit during RESP; reset clears the whole array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mem_we_c) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wstrb_q[b]) mem[addr_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_arb_mc.sv
// Scoreboard bench for mem_arb_mc: two instances (RD_LAT=1 and 3) with
// WIDTH=16, DEPTH=20, NUM_CH=2 run the same directed sequence in turn.
module tb_mem_arb_mc;

    localparam int W    = 16;
    localparam int D    = 20;
    localparam int NC   = 2;
    localparam int AW   = 5;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    typedef struct {
        int          ch;
        logic        err;
        logic [W-1:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst   [2];
    logic [NC-1:0]     valid [2];
    logic [NC-1:0]     wr_rd [2];
    logic [NC*AW-1:0]  addr  [2];
    logic [NC*W-1:0]   wdata [2];
    logic [NC*W/8-1:0] wstrb [2];
    logic [NC-1:0]     ready [2];
    logic [NC*W-1:0]   rdata [2];
    logic [NC-1:0]     err   [2];

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    mem_arb_mc #(.WIDTH(W), .DEPTH(D), .NUM_CH(NC), .ADDR_WIDTH(AW), .RD_LAT(LAT0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .valid(valid[0]), .wr_rd(wr_rd[0]), .addr(addr[0]),
        .wdata(wdata[0]), .wstrb(wstrb[0]), .ready(ready[0]), .rdata(rdata[0]), .err(err[0])
    );

    mem_arb_mc #(.WIDTH(W), .DEPTH(D), .NUM_CH(NC), .ADDR_WIDTH(AW), .RD_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .valid(valid[1]), .wr_rd(wr_rd[1]), .addr(addr[1]),
        .wdata(wdata[1]), .wstrb(wstrb[1]), .ready(ready[1]), .rdata(rdata[1]), .err(err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT0 : LAT1;
    endfunction

    task automatic push(input int d, input int ch, input logic e_err, input logic [W-1:0] e_rd);
        exp_t e;
        e.ch = ch; e.err = e_err; e.rdata = e_rd;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: every ready bit pops one expectation; idle channels must be quiet.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < NC; c++) begin
                    if (ready[d][c] === 1'b1) begin
                        have = 1'b0;
                        if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                        if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                        if (!have) begin
                            checks++; errors++;
                            $display("FAIL d%0d unexpected ready on ch%0d at %0t", d, c, $time);
                        end else begin
                            check($sformatf("d%0d grant ch", d), 32'(c), 32'(e.ch));
                            check($sformatf("d%0d err ch%0d", d, c), 32'(err[d][c]), 32'(e.err));
                            check($sformatf("d%0d rdata ch%0d", d, c), 32'(rdata[d][c*W +: W]), 32'(e.rdata));
                        end
                    end else begin
                        check($sformatf("d%0d idle err ch%0d", d, c), 32'(err[d][c]), 32'd0);
                        check($sformatf("d%0d idle rdata ch%0d", d, c), 32'(rdata[d][c*W +: W]), 32'd0);
                    end
                end
            end
        end
    end

    task automatic do_reset(input int d);
        rst[d] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check($sformatf("d%0d reset ready", d), 32'(ready[d]), 32'd0);
        check($sformatf("d%0d reset err", d), 32'(err[d]), 32'd0);
        check($sformatf("d%0d reset rdata", d), rdata[d], 32'd0);
        rst[d] = 1'b1;
    endtask

    // One transfer from an idle DUT; ready is expected RD_LAT+1 edges after valid.
    task automatic xfer(input int d, input int ch, input bit wr, input int a,
                        input logic [W-1:0] data, input logic [1:0] strb,
                        input logic e_err, input logic [W-1:0] e_rd, input bit drop);
        int n;
        bit seen;
        push(d, ch, e_err, e_rd);
        @(posedge clk);
        @(negedge clk);
        valid[d][ch]            = 1'b1;
        wr_rd[d][ch]            = wr;
        addr[d][ch*AW +: AW]    = AW'(a);
        wdata[d][ch*W +: W]     = data;
        wstrb[d][ch*2 +: 2]     = strb;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (drop) valid[d][ch] = 1'b0;
            if (ready[d][ch] === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL d%0d timeout ch%0d addr %0d: no ready within 30 cycles", d, ch, a);
        end else begin
            check($sformatf("d%0d latency addr%0d", d, a), 32'(n), 32'(lat_of(d) + 1));
        end
        valid[d][ch] = 1'b0;
    endtask

    // Both channels request continuously; grants must alternate 0,1,0,1...
    task automatic rr_burst(input int d, input logic [W-1:0] d0, input logic [W-1:0] d1);
        int cnt, cyc, last;
        for (int i = 0; i < 8; i++) push(d, i % 2, 1'b0, (i % 2 == 0) ? d0 : d1);
        @(posedge clk);
        @(negedge clk);
        valid[d] = 2'b11;
        wr_rd[d] = 2'b00;
        addr[d]  = {5'd5, 5'd3};
        cnt = 0; cyc = 0; last = -1;
        while (cnt < 8 && cyc < 200) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (|ready[d]) begin
                if (last >= 0) check($sformatf("d%0d rr period", d), 32'(cyc - last), 32'(lat_of(d) + 2));
                last = cyc;
                cnt++;
            end
        end
        if (cnt < 8) begin
            checks++; errors++;
            $display("FAIL d%0d rr timeout: got %0d readies, expected 8", d, cnt);
        end
        valid[d] = 2'b00;
    endtask

    // Reset lands while a write sits in ACCESS; nothing may complete.
    task automatic abort_write(input int d);
        @(posedge clk);
        @(negedge clk);
        valid[d][0]        = 1'b1;
        wr_rd[d][0]        = 1'b1;
        addr[d][0 +: AW]   = AW'(7);
        wdata[d][0 +: W]   = 16'h0077;
        wstrb[d][0 +: 2]   = 2'b11;
        @(posedge clk);
        @(negedge clk);
        rst[d]      = 1'b0;
        valid[d][0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check($sformatf("d%0d abort ready", d), 32'(ready[d]), 32'd0);
        rst[d] = 1'b1;
    endtask

    task automatic run_seq(input int d);
        do_reset(d);
        for (int a = 0; a < D; a++) xfer(d, a % 2, 1'b0, a, 16'h0, 2'b00, 1'b0, 16'h0, 1'b0);
        xfer(d, 0, 1'b1, 3, 16'h00A5, 2'b01, 1'b0, 16'h0, 1'b0);
        xfer(d, 0, 1'b0, 3, 16'h0, 2'b00, 1'b0, 16'h00A5, 1'b0);
        xfer(d, 1, 1'b1, 5, 16'h1234, 2'b11, 1'b0, 16'h0, 1'b0);
        xfer(d, 1, 1'b1, 5, 16'hFF00, 2'b10, 1'b0, 16'h0, 1'b0);
        xfer(d, 0, 1'b0, 5, 16'h0, 2'b00, 1'b0, 16'hFF34, 1'b0);
        xfer(d, 0, 1'b1, 3, 16'hFFFF, 2'b00, 1'b0, 16'h0, 1'b0);
        xfer(d, 1, 1'b0, 3, 16'h0, 2'b00, 1'b0, 16'h00A5, 1'b0);
        xfer(d, 1, 1'b1, 25, 16'hBEEF, 2'b11, 1'b1, 16'h0, 1'b0);
        xfer(d, 0, 1'b0, 25, 16'h0, 2'b00, 1'b1, 16'h0, 1'b0);
        xfer(d, 1, 1'b0, 5, 16'h0, 2'b00, 1'b0, 16'hFF34, 1'b0);
        rr_burst(d, 16'h00A5, 16'hFF34);
        abort_write(d);
        xfer(d, 0, 1'b0, 7, 16'h0, 2'b00, 1'b0, 16'h0, 1'b0);
        xfer(d, 1, 1'b0, 3, 16'h0, 2'b00, 1'b0, 16'h0, 1'b0);
        xfer(d, 0, 1'b1, 2, 16'h5A5A, 2'b11, 1'b0, 16'h0, 1'b1);
        xfer(d, 1, 1'b0, 2, 16'h0, 2'b00, 1'b0, 16'h5A5A, 1'b0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0; valid[d] = '0; wr_rd[d] = '0;
            addr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        mon_en = 1'b1;
        run_seq(0);
        run_seq(1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++; errors++;
            $display("FAIL leftover expectations: q0=%0d q1=%0d, expected 0", q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
